// File: rtl/m2s_stream_drainer.sv
// m2s_stream_drainer
//   Drains 16-bit words from the m2s FIFO read slave (Avalon-MM read master,
//   fixed read latency 1) and re-emits them as a fixed-length packetised
//   Avalon-ST source with SOP/EOP. Words are staged in a 2-entry output buffer
//   whose head drives src_*.
//
//   Optional feature: define M2S_DRAIN_CHECKSUM_EN to append a 16-bit
//   modulo-2^16 sum word to every packet. The checksum word carries EOP.
//
// Ports
//   clock, reset_n   rising-edge clock, asynchronous active-low reset
//   enable           1 = issue new reads, 0 = pause (pending request completes)
//   avm_read         read request (combinational from registered state and src_ready)
//   avm_readdata     FIFO data, captured the cycle after an accepted read
//   avm_waitrequest  FIFO empty, stalls avm_read
//   src_data/valid/ready/sop/eop  stream source, ready latency 0
//   busy             read in flight or output buffer not empty
//   pkt_count        completed packets (EOP beats transferred), wraps

module m2s_stream_drainer #(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned PKT_LEN   = 64,
  parameter int unsigned PKT_CNT_W = 8
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              enable,
  output logic              avm_read,
  input  logic [DATA_W-1:0] avm_readdata,
  input  logic              avm_waitrequest,
  output logic [DATA_W-1:0] src_data,
  output logic              src_valid,
  input  logic              src_ready,
  output logic              src_sop,
  output logic              src_eop,
  output logic              busy,
  output logic [15:0]       pkt_count
);

  localparam int unsigned OCC_W = 2;
  localparam int unsigned PCNT_W = 16;
  localparam logic [PKT_CNT_W-1:0] LAST_IDX = PKT_CNT_W'(PKT_LEN - 1);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              sop;
    logic              eop;
  } beat_t;

  // Registered state
  logic                 armed_q;
  logic                 hold_q;
  logic                 inflight_q;
  logic [OCC_W-1:0]     occ_q, occ_d;
  beat_t                slot0_q, slot0_d;
  beat_t                slot1_q, slot1_d;
  logic [PKT_CNT_W-1:0] wcnt_q, wcnt_d;
  logic [PCNT_W-1:0]    pkt_count_q, pkt_count_d;

  logic  beat;
  logic  accept;
  logic  room;
  logic  push;
  logic  csum_pend;
  beat_t push_beat;
  beat_t cap_beat;

  // Stream side is driven straight from the buffer head
  assign src_valid = (occ_q != '0);
  assign src_data  = slot0_q.data;
  assign src_sop   = src_valid & slot0_q.sop;
  assign src_eop   = src_valid & slot0_q.eop;
  assign busy      = inflight_q | src_valid;
  assign pkt_count = pkt_count_q;

  assign beat   = src_valid & src_ready;
  assign accept = avm_read & ~avm_waitrequest;

  // A new read is allowed while buffer + in-flight, less the beat leaving this
  // cycle, stays below 2; crediting the beat gives 1 word/cycle sustained.
  assign room     = ((3'(occ_q) + 3'(inflight_q)) < (3'd2 + 3'(beat)));
  assign avm_read = armed_q & (hold_q | (enable & ~csum_pend & room));

`ifdef M2S_DRAIN_CHECKSUM_EN
  logic [PKT_CNT_W-1:0] acc_cnt_q, acc_cnt_d;
  logic                 pend_q, pend_d;
  logic [DATA_W-1:0]    csum_q, csum_d;
  logic                 acc_last;
  logic                 csum_push;

  assign csum_pend = pend_q;
  assign acc_last  = (acc_cnt_q == LAST_IDX);
  // Last data word already captured (nothing in flight) and a slot is free
  assign csum_push = pend_q & ~inflight_q & ((occ_q != 2'd2) | beat);
  assign cap_beat  = '{data: avm_readdata, sop: (wcnt_q == '0), eop: 1'b0};
  assign push      = inflight_q | csum_push;
  assign push_beat = csum_push ? beat_t'{data: csum_q, sop: 1'b0, eop: 1'b1} : cap_beat;

  // Checksum accumulator and end-of-packet request tracking
  always_comb begin
    acc_cnt_d = acc_cnt_q;
    pend_d    = pend_q;
    csum_d    = csum_q;
    if (accept) begin
      acc_cnt_d = acc_last ? '0 : acc_cnt_q + PKT_CNT_W'(1);
      if (acc_last) pend_d = 1'b1;
    end
    if (inflight_q) csum_d = csum_q + avm_readdata;
    if (csum_push) begin
      pend_d = 1'b0;
      csum_d = '0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      acc_cnt_q <= '0;
      pend_q    <= 1'b0;
      csum_q    <= '0;
    end else begin
      acc_cnt_q <= acc_cnt_d;
      pend_q    <= pend_d;
      csum_q    <= csum_d;
    end
  end
`else
  assign csum_pend = 1'b0;
  assign cap_beat  = '{data: avm_readdata, sop: (wcnt_q == '0), eop: (wcnt_q == LAST_IDX)};
  assign push      = inflight_q;
  assign push_beat = cap_beat;
`endif

  // Output buffer, word counter and packet counter next state
  always_comb begin
    occ_d       = occ_q;
    slot0_d     = slot0_q;
    slot1_d     = slot1_q;
    wcnt_d      = wcnt_q;
    pkt_count_d = pkt_count_q;

    case ({push, beat})
      2'b10: begin
        if (occ_q == '0) slot0_d = push_beat;
        else             slot1_d = push_beat;
        occ_d = occ_q + OCC_W'(1);
      end
      2'b01: begin
        slot0_d = slot1_q;
        occ_d   = occ_q - OCC_W'(1);
      end
      2'b11: begin
        if (occ_q == OCC_W'(1)) begin
          slot0_d = push_beat;
        end else begin
          slot0_d = slot1_q;
          slot1_d = push_beat;
        end
      end
      default: ;
    endcase

    if (inflight_q) wcnt_d = (wcnt_q == LAST_IDX) ? '0 : wcnt_q + PKT_CNT_W'(1);
    if (beat && src_eop) pkt_count_d = pkt_count_q + PCNT_W'(1);
  end

  // State registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      armed_q     <= 1'b0;
      hold_q      <= 1'b0;
      inflight_q  <= 1'b0;
      occ_q       <= '0;
      slot0_q     <= '0;
      slot1_q     <= '0;
      wcnt_q      <= '0;
      pkt_count_q <= '0;
    end else begin
      armed_q     <= 1'b1;
      hold_q      <= avm_read & avm_waitrequest;
      inflight_q  <= accept;
      occ_q       <= occ_d;
      slot0_q     <= slot0_d;
      slot1_q     <= slot1_d;
      wcnt_q      <= wcnt_d;
      pkt_count_q <= pkt_count_d;
    end
  end

endmodule

// File: tb/tb_m2s_stream_drainer.sv
module tb_m2s_stream_drainer;

  localparam int unsigned DATA_W    = 16;
  localparam int unsigned PKT_LEN   = 4;
  localparam int unsigned PKT_CNT_W = 8;
`ifdef M2S_DRAIN_CHECKSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif

  typedef struct {
    logic [DATA_W-1:0] data;
    logic              sop;
    logic              eop;
    logic              csum;
  } exp_t;

  logic              clock;
  logic              reset_n;
  logic              enable;
  logic              avm_read;
  logic [DATA_W-1:0] avm_readdata;
  logic              avm_waitrequest;
  logic [DATA_W-1:0] src_data;
  logic              src_valid;
  logic              src_ready;
  logic              src_sop;
  logic              src_eop;
  logic              busy;
  logic [15:0]       pkt_count;

  m2s_stream_drainer #(
    .DATA_W   (DATA_W),
    .PKT_LEN  (PKT_LEN),
    .PKT_CNT_W(PKT_CNT_W)
  ) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .enable         (enable),
    .avm_read       (avm_read),
    .avm_readdata   (avm_readdata),
    .avm_waitrequest(avm_waitrequest),
    .src_data       (src_data),
    .src_valid      (src_valid),
    .src_ready      (src_ready),
    .src_sop        (src_sop),
    .src_eop        (src_eop),
    .busy           (busy),
    .pkt_count      (pkt_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  logic [DATA_W-1:0] fifo[$];
  exp_t              sb[$];
  logic [DATA_W-1:0] rd_pend = '0;
  int                model_idx = 0;
  logic [DATA_W-1:0] model_sum = '0;
  int                exp_pkts = 0;
  int                accepts = 0;
  int                data_beats = 0;
  bit                tog_ready = 1'b0;
  bit                stall_prev = 1'b0;
  logic [DATA_W-1:0] prev_data = '0;
  logic              prev_sop = 1'b0;
  logic              prev_eop = 1'b0;
  int                cyc = 0;
  int                last_acc_cyc = -1;
  int                max_gap = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Write a word into the FIFO and push its expected beat(s)
  task automatic fifo_write(input logic [DATA_W-1:0] d);
    exp_t e;
    fifo.push_back(d);
    e.data = d;
    e.sop  = (model_idx == 0);
    e.eop  = (model_idx == PKT_LEN - 1) && !CSUM;
    e.csum = 1'b0;
    sb.push_back(e);
    model_sum = model_sum + d;
    model_idx++;
    if (model_idx == PKT_LEN) begin
      model_idx = 0;
      if (CSUM) begin
        e.data = model_sum;
        e.sop  = 1'b0;
        e.eop  = 1'b1;
        e.csum = 1'b1;
        sb.push_back(e);
      end
      model_sum = '0;
    end
  endtask

  // One clock: drive inputs at negedge, sample outputs 1 time unit later
  task automatic tick();
    exp_t e;
    @(negedge clock);
    cyc++;
    avm_readdata = rd_pend;
    if (tog_ready) src_ready = ~src_ready;
    avm_waitrequest = (fifo.size() == 0);
    #1;
    if (stall_prev) begin
      check("stall_valid", 32'(src_valid), 32'd1);
      check("stall_data", 32'(src_data), 32'(prev_data));
      check("stall_sop", 32'(src_sop), 32'(prev_sop));
      check("stall_eop", 32'(src_eop), 32'(prev_eop));
    end
    if (src_valid && src_ready) begin
      if (sb.size() == 0) begin
        check("sb_underflow", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("beat_data", 32'(src_data), 32'(e.data));
        check("beat_sop", 32'(src_sop), 32'(e.sop));
        check("beat_eop", 32'(src_eop), 32'(e.eop));
        if (e.eop) exp_pkts++;
        if (!e.csum) data_beats++;
      end
    end
    stall_prev = src_valid && !src_ready;
    prev_data  = src_data;
    prev_sop   = src_sop;
    prev_eop   = src_eop;
    if (avm_read && !avm_waitrequest) begin
      rd_pend = fifo.pop_front();
      accepts++;
      if (last_acc_cyc >= 0 && (cyc - last_acc_cyc) > max_gap) max_gap = cyc - last_acc_cyc;
      last_acc_cyc = cyc;
    end
    check("occ_bound", 32'((accepts - data_beats) <= 2), 32'd1);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((sb.size() != 0 || busy) && n < 300) begin
      tick();
      n++;
    end
    check({tag, "_drain_done"}, 32'(n < 300), 32'd1);
  endtask

  initial begin
    reset_n         = 1'b0;
    enable          = 1'b1;
    src_ready       = 1'b1;
    avm_waitrequest = 1'b1;
    avm_readdata    = '0;
    #1;
    check("rst_avm_read", 32'(avm_read), 32'd0);
    check("rst_src_valid", 32'(src_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_pkt_count", 32'(pkt_count), 32'd0);

    // 1: preloaded 1..8, ready held high
    for (int i = 1; i <= 8; i++) fifo_write(DATA_W'(i));
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    last_acc_cyc = -1;
    max_gap = 0;
    drain("t1");
    check("t1_pkt_count", 32'(pkt_count), 32'd2);
    check("t1_accepts", 32'(accepts), 32'd8);
`ifndef M2S_DRAIN_CHECKSUM_EN
    check("t1_back_to_back", 32'(max_gap), 32'd1);
`endif

    // 2: ready toggles every cycle, 16 words
    for (int i = 9; i <= 24; i++) fifo_write(DATA_W'(i));
    tog_ready = 1'b1;
    drain("t2");
    tog_ready = 1'b0;
    src_ready = 1'b1;
    check("t2_pkt_count", 32'(pkt_count), 32'(exp_pkts));
    check("t2_pkt_count_abs", 32'(pkt_count), 32'd6);

    // 3: FIFO runs empty mid-packet for 10 cycles
    fifo_write(DATA_W'(25));
    fifo_write(DATA_W'(26));
    repeat (6) tick();
    for (int i = 0; i < 10; i++) begin
      tick();
      check("t3_read_held", 32'(avm_read), 32'd1);
    end
    fifo_write(DATA_W'(27));
    fifo_write(DATA_W'(28));
    drain("t3");
    check("t3_pkt_count", 32'(pkt_count), 32'd7);

    // 4: pause with a pending request stalled by waitrequest
    fifo_write(DATA_W'(29));
    fifo_write(DATA_W'(30));
    repeat (6) tick();
    enable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t4_read_hold", 32'(avm_read), 32'd1);
    end
    fifo_write(DATA_W'(31));
    tick();
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t4_read_drop", 32'(avm_read), 32'd0);
    end
    enable = 1'b1;
    fifo_write(DATA_W'(32));
    drain("t4");
    check("t4_pkt_count", 32'(pkt_count), 32'd8);

    // 5: reset mid-packet after 2 of 4 words
    fifo_write(DATA_W'(33));
    fifo_write(DATA_W'(34));
    drain("t5a");
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    check("t5_rst_avm_read", 32'(avm_read), 32'd0);
    check("t5_rst_valid", 32'(src_valid), 32'd0);
    check("t5_rst_sop", 32'(src_sop), 32'd0);
    check("t5_rst_eop", 32'(src_eop), 32'd0);
    check("t5_rst_busy", 32'(busy), 32'd0);
    check("t5_rst_pkt_count", 32'(pkt_count), 32'd0);
    model_idx = 0;
    model_sum = '0;
    exp_pkts  = 0;
    stall_prev = 1'b0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    for (int i = 37; i <= 40; i++) fifo_write(DATA_W'(i));
    drain("t5b");
    check("t5_pkt_count", 32'(pkt_count), 32'd1);

    // 6: checksum wrap data (plain packet when the checksum is not built in)
    fifo_write(16'hFFFF);
    fifo_write(16'h0002);
    fifo_write(16'h0003);
    fifo_write(16'h0004);
    drain("t6");
    check("t6_pkt_count", 32'(pkt_count), 32'd2);
    check("t6_sb_empty", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
